// File: rtl/clock_set_ctrl_if.sv
// Button, time-counter and display signals of the clock-setting controller.
// The slave modport is the controller; master is the surrounding system.
interface clock_set_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [5:0] cur_mins;
    logic [4:0] cur_hrs;
    logic       run_en;
    logic       load;
    logic [5:0] load_mins;
    logic [4:0] load_hrs;
    logic [5:0] disp_mins;
    logic [4:0] disp_hrs;
    logic [1:0] mode;
    logic [3:0] digit_blank;

    modport master (
        output btn_mode, btn_inc, cur_mins, cur_hrs,
        input  run_en, load, load_mins, load_hrs,
        input  disp_mins, disp_hrs, mode, digit_blank
    );

    modport slave (
        input  btn_mode, btn_inc, cur_mins, cur_hrs,
        output run_en, load, load_mins, load_hrs,
        output disp_mins, disp_hrs, mode, digit_blank
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Clock-setting controller: debounced mode/inc buttons drive a RUN -> SET_HRS ->
// SET_MINS edit cycle that loads the time counter and blinks the digits being edited.
//
// state        | meaning
// -------------+--------------------------------------------------------------
// ST_RUN       | time counter free-running, display shows cur_*
// ST_SET_HRS   | editing hours, hours digits blink, counter halted
// ST_SET_MINS  | editing minutes, minutes digits blink, counter halted
// ST_BAD       | unused encoding, falls back to ST_RUN without a load
module clock_set_ctrl #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input logic             clk,
    input logic             reset,
    clock_set_ctrl_if.slave bus
);

    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DB_W-1:0] DB_TC = DB_W'(DB_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_TC = BL_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HRS  = 2'd1,
        ST_SET_MINS = 2'd2,
        ST_BAD      = 2'd3
    } state_t;

    // Index 0 is the mode button, index 1 the increment button.
    logic [1:0]      raw_btn;
    logic [1:0]      sync_a;
    logic [1:0]      sync_b;
    logic [1:0]      accepted;
    logic [1:0]      accepted_q;
    logic [DB_W-1:0] db_cnt [2];
    logic            press_mode;
    logic            press_inc;

    state_t          state;
    logic            run_en_r;
    logic            load_r;
    logic [4:0]      hrs_r;
    logic [5:0]      mins_r;
    logic [BL_W-1:0] blink_cnt;
    logic            blink_blank;

    logic [4:0]      hrs_cap;
    logic [5:0]      mins_cap;
    logic [4:0]      hrs_next;
    logic [5:0]      mins_next;
    logic [BL_W-1:0] blink_cnt_tick;
    logic            blink_blank_tick;
    logic [3:0]      blank_mask;
    logic            editing;

    assign raw_btn = {bus.btn_inc, bus.btn_mode};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a     <= '0;
            sync_b     <= '0;
            accepted   <= '0;
            accepted_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_a     <= raw_btn;
            sync_b     <= sync_a;
            accepted_q <= accepted;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == accepted[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_TC) begin
                    accepted[i] <= sync_b[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign press_mode = accepted[0] & ~accepted_q[0];
    assign press_inc  = accepted[1] & ~accepted_q[1];

    // Out-of-range captures from the time counter are edited from zero.
    assign hrs_cap   = (bus.cur_hrs  > 5'd23) ? 5'd0 : bus.cur_hrs;
    assign mins_cap  = (bus.cur_mins > 6'd59) ? 6'd0 : bus.cur_mins;
    assign hrs_next  = (hrs_r  == 5'd23) ? 5'd0 : hrs_r  + 5'd1;
    assign mins_next = (mins_r == 6'd59) ? 6'd0 : mins_r + 6'd1;

    always_comb begin
        blink_cnt_tick   = blink_cnt + BL_W'(1);
        blink_blank_tick = blink_blank;
        if (blink_cnt == BL_TC) begin
            blink_cnt_tick   = '0;
            blink_blank_tick = ~blink_blank;
        end
    end

    // A mode press is checked first in every state, so a coincident inc press is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            run_en_r    <= 1'b1;
            load_r      <= 1'b0;
            hrs_r       <= '0;
            mins_r      <= '0;
            blink_cnt   <= '0;
            blink_blank <= 1'b0;
        end else begin
            load_r <= 1'b0;
            case (state)
                ST_RUN: begin
                    run_en_r    <= 1'b1;
                    blink_cnt   <= '0;
                    blink_blank <= 1'b0;
                    if (press_mode) begin
                        state    <= ST_SET_HRS;
                        run_en_r <= 1'b0;
                        hrs_r    <= hrs_cap;
                        mins_r   <= mins_cap;
                    end
                end
                ST_SET_HRS: begin
                    if (press_mode) begin
                        state       <= ST_SET_MINS;
                        blink_cnt   <= '0;
                        blink_blank <= 1'b0;
                    end else if (press_inc) begin
                        hrs_r       <= hrs_next;
                        blink_cnt   <= '0;
                        blink_blank <= 1'b0;
                    end else begin
                        blink_cnt   <= blink_cnt_tick;
                        blink_blank <= blink_blank_tick;
                    end
                end
                ST_SET_MINS: begin
                    if (press_mode) begin
                        state       <= ST_RUN;
                        load_r      <= 1'b1;
                        run_en_r    <= 1'b1;
                        blink_cnt   <= '0;
                        blink_blank <= 1'b0;
                    end else if (press_inc) begin
                        mins_r      <= mins_next;
                        blink_cnt   <= '0;
                        blink_blank <= 1'b0;
                    end else begin
                        blink_cnt   <= blink_cnt_tick;
                        blink_blank <= blink_blank_tick;
                    end
                end
                default: begin
                    state       <= ST_RUN;
                    run_en_r    <= 1'b1;
                    blink_cnt   <= '0;
                    blink_blank <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        blank_mask = 4'b0000;
        if (blink_blank) begin
            case (state)
                ST_SET_HRS:  blank_mask = 4'b1100;
                ST_SET_MINS: blank_mask = 4'b0011;
                default:     blank_mask = 4'b0000;
            endcase
        end
    end

    assign editing = (state == ST_SET_HRS) || (state == ST_SET_MINS);

    assign bus.run_en      = run_en_r;
    assign bus.load        = load_r;
    assign bus.load_mins   = mins_r;
    assign bus.load_hrs    = hrs_r;
    assign bus.disp_mins   = editing ? mins_r : bus.cur_mins;
    assign bus.disp_hrs    = editing ? hrs_r  : bus.cur_hrs;
    assign bus.mode        = state;
    assign bus.digit_blank = blank_mask;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed button sequences push expected output events
// into a queue; a negedge monitor pops one per observed change of the edit outputs.
module tb_clock_set_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;

    clock_set_ctrl_if bus ();

    clock_set_ctrl #(
        .DB_CYCLES (4),
        .BLINK_DIV (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Event layout: {mode[1:0], load, load_hrs[4:0], load_mins[5:0], run_en}
    logic [14:0] exp_q [$];

    function automatic logic [14:0] ev(input logic [1:0] m, input logic l,
                                       input logic [4:0] h, input logic [5:0] mi,
                                       input logic r);
        return {m, l, h, mi, r};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_ev(input logic [14:0] act, input logic [14:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL event: got mode=%0d load=%0d hrs=%0d mins=%0d run_en=%0d expected mode=%0d load=%0d hrs=%0d mins=%0d run_en=%0d",
                      act[14:13], act[12], act[11:7], act[6:1], act[0],
                      exp[14:13], exp[12], exp[11:7], exp[6:1], exp[0]);
    endtask

    initial begin : monitor
        logic [14:0] prev;
        logic [14:0] snap;
        bit          have;
        have = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            snap = {bus.mode, bus.load, bus.load_hrs, bus.load_mins, bus.run_en};
            if (!have || snap !== prev) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_event: got mode=%0d load=%0d hrs=%0d mins=%0d run_en=%0d expected no change",
                             snap[14:13], snap[12], snap[11:7], snap[6:1], snap[0]);
                end else begin
                    chk_ev(snap, exp_q.pop_front());
                end
                have = 1'b1;
                prev = snap;
            end
        end
    end

    task automatic press(input logic m, input logic i, input int hold);
        bus.btn_mode = m;
        bus.btn_inc  = i;
        repeat (hold) @(posedge clk);
        #1;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        int waited;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.cur_hrs  = 5'd10;
        bus.cur_mins = 6'd30;
        reset        = 1'b1;
        exp_q.push_back(ev(2'd0, 1'b0, 5'd0, 6'd0, 1'b1));
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mode", bus.mode, 0);
        chk("rst_run_en", bus.run_en, 1);
        chk("rst_load", bus.load, 0);
        chk("rst_digit_blank", bus.digit_blank, 0);
        chk("rst_load_hrs", bus.load_hrs, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("disp_run_hrs", bus.disp_hrs, 10);
        chk("disp_run_mins", bus.disp_mins, 30);

        // inc in RUN must not produce any event
        press(1'b0, 1'b1, 10);

        // long mode hold: exactly one transition with capture
        exp_q.push_back(ev(2'd1, 1'b0, 5'd10, 6'd30, 1'b0));
        press(1'b1, 1'b0, 20);
        bus.cur_hrs = 5'd2;
        #1;
        chk("run_en_in_set", bus.run_en, 0);
        chk("disp_edit_hrs", bus.disp_hrs, 10);

        // short glitch, then a proper long hold
        press(1'b0, 1'b1, 3);
        exp_q.push_back(ev(2'd1, 1'b0, 5'd11, 6'd30, 1'b0));
        press(1'b0, 1'b1, 10);

        for (int h = 12; h <= 23; h++) begin
            exp_q.push_back(ev(2'd1, 1'b0, 5'(h), 6'd30, 1'b0));
            press(1'b0, 1'b1, 6);
        end
        exp_q.push_back(ev(2'd1, 1'b0, 5'd0, 6'd30, 1'b0));
        press(1'b0, 1'b1, 6);

        exp_q.push_back(ev(2'd2, 1'b0, 5'd0, 6'd30, 1'b0));
        press(1'b1, 1'b0, 6);
        for (int m = 31; m <= 59; m++) begin
            exp_q.push_back(ev(2'd2, 1'b0, 5'd0, 6'(m), 1'b0));
            press(1'b0, 1'b1, 6);
        end
        exp_q.push_back(ev(2'd2, 1'b0, 5'd0, 6'd0, 1'b0));
        press(1'b0, 1'b1, 6);

        exp_q.push_back(ev(2'd0, 1'b1, 5'd0, 6'd0, 1'b1));
        exp_q.push_back(ev(2'd0, 1'b0, 5'd0, 6'd0, 1'b1));
        press(1'b1, 1'b0, 6);

        // capture 07:45, simultaneous mode+inc, then load
        bus.cur_hrs  = 5'd7;
        bus.cur_mins = 6'd45;
        exp_q.push_back(ev(2'd1, 1'b0, 5'd7, 6'd45, 1'b0));
        press(1'b1, 1'b0, 6);
        exp_q.push_back(ev(2'd2, 1'b0, 5'd7, 6'd45, 1'b0));
        press(1'b1, 1'b1, 6);
        exp_q.push_back(ev(2'd0, 1'b1, 5'd7, 6'd45, 1'b1));
        exp_q.push_back(ev(2'd0, 1'b0, 5'd7, 6'd45, 1'b1));
        press(1'b1, 1'b0, 6);

        // minutes out of range captured as zero
        bus.cur_hrs  = 5'd23;
        bus.cur_mins = 6'd60;
        exp_q.push_back(ev(2'd1, 1'b0, 5'd23, 6'd0, 1'b0));
        press(1'b1, 1'b0, 6);
        exp_q.push_back(ev(2'd2, 1'b0, 5'd23, 6'd0, 1'b0));
        press(1'b1, 1'b0, 6);
        exp_q.push_back(ev(2'd0, 1'b1, 5'd23, 6'd0, 1'b1));
        exp_q.push_back(ev(2'd0, 1'b0, 5'd23, 6'd0, 1'b1));
        press(1'b1, 1'b0, 6);

        // hours out of range captured as zero
        bus.cur_hrs  = 5'd25;
        bus.cur_mins = 6'd45;
        exp_q.push_back(ev(2'd1, 1'b0, 5'd0, 6'd45, 1'b0));
        press(1'b1, 1'b0, 6);

        // enter SET_MINS and watch the blink cadence
        exp_q.push_back(ev(2'd2, 1'b0, 5'd0, 6'd45, 1'b0));
        bus.btn_mode = 1'b1;
        waited = 0;
        @(negedge clk);
        while (bus.mode != 2'd2 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("enter_set_mins", bus.mode, 2);
        bus.btn_mode = 1'b0;
        for (int k = 0; k < 40; k++) begin
            chk("blink", bus.digit_blank, (((k / 8) % 2) == 1) ? 3 : 0);
            @(negedge clk);
        end
        chk("blink_before_reset", bus.digit_blank, 3);

        // reset in the middle of the edit
        exp_q.push_back(ev(2'd0, 1'b0, 5'd0, 6'd0, 1'b1));
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_mode", bus.mode, 0);
        chk("midreset_load", bus.load, 0);
        chk("midreset_digit_blank", bus.digit_blank, 0);
        chk("midreset_load_mins", bus.load_mins, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        bus.cur_hrs  = 5'd3;
        bus.cur_mins = 6'd15;
        exp_q.push_back(ev(2'd1, 1'b0, 5'd3, 6'd15, 1'b0));
        press(1'b1, 1'b0, 6);
        bus.cur_hrs = 5'd9;
        #1;
        chk("disp_after_reset", bus.disp_hrs, 3);

        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
